// File: rtl/bcd_display_scan.sv
// Latches the two-digit BCD result when the counting window closes and scans it onto a 2-digit mux 7-seg display.
// Seg/Anode are registered (one cycle after scan state); held content refreshes at the start of each lit slot; no backpressure.
module bcd_display_scan #(
  parameter int unsigned SCAN_DIV = 16,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Enable,
  input  logic [3:0] Digit0,
  input  logic [3:0] Digit1,
  input  logic       Carry,
  output logic [7:0] Seg,
  output logic [1:0] Anode,
  output logic       Valid,
  output logic       Overflow
);

  typedef enum logic [1:0] {
    D0 = 2'd0,
    G0 = 2'd1,
    D1 = 2'd2,
    G1 = 2'd3
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(SCAN_DIV - 1);
  localparam logic [7:0] SEG_DASH = 8'h40;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       en_q, en_d;
  logic       ovf_q, ovf_d;
  logic [3:0] hold0_q, hold0_d;
  logic [3:0] hold1_q, hold1_d;
  logic       valid_q, valid_d;
  logic       overflow_q, overflow_d;
  logic [7:0] seg_q, seg_d;
  logic [1:0] anode_q, anode_d;

  logic       capture;
  logic       win_rise;
  logic [3:0] slot_digit;
  logic [7:0] lit_seg;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h40;
    endcase
  endfunction

  always_comb begin
    capture  = en_q & ~Enable;
    win_rise = ~en_q & Enable;

    en_d       = Enable;
    // A new window forgets the previous overflow; a Carry on the opening cycle still counts.
    ovf_d      = (win_rise ? 1'b0 : ovf_q) | (Enable & Carry);
    hold0_d    = hold0_q;
    hold1_d    = hold1_q;
    valid_d    = valid_q;
    overflow_d = overflow_q;
    if (capture) begin
      hold0_d    = Digit0;
      hold1_d    = Digit1;
      overflow_d = ovf_q | Carry;
      valid_d    = 1'b1;
    end

    slot_digit = (state_q == D1) ? hold1_q : hold0_q;
    if (!valid_q || overflow_q) begin
      lit_seg = SEG_DASH;
    end else if ((state_q == D1) && BLANK_LZ && (hold1_q == 4'd0)) begin
      lit_seg = 8'h00;
    end else begin
      lit_seg = {1'b0, seg7(slot_digit)};
    end

    state_d = state_q;
    cnt_d   = cnt_q;
    seg_d   = seg_q;
    anode_d = anode_q;
    case (state_q)
      D0, D1: begin
        anode_d = (state_q == D0) ? 2'b01 : 2'b10;
        // Content is sampled once per slot so a capture never changes a digit mid-slot.
        if (cnt_q == 8'd0) seg_d = lit_seg;
        if (cnt_q == CNT_LAST) begin
          state_d = (state_q == D0) ? G0 : G1;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        anode_d = 2'b00;
        seg_d   = 8'h00;
        state_d = (state_q == G0) ? D1 : D0;
        cnt_d   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q    <= D0;
      cnt_q      <= 8'd0;
      en_q       <= 1'b0;
      ovf_q      <= 1'b0;
      hold0_q    <= 4'd0;
      hold1_q    <= 4'd0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
      seg_q      <= 8'h00;
      anode_q    <= 2'b00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      en_q       <= en_d;
      ovf_q      <= ovf_d;
      hold0_q    <= hold0_d;
      hold1_q    <= hold1_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
      seg_q      <= seg_d;
      anode_q    <= anode_d;
    end
  end

  assign Seg      = seg_q;
  assign Anode    = anode_q;
  assign Valid    = valid_q;
  assign Overflow = overflow_q;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Directed bench for bcd_display_scan with SCAN_DIV=4; a second instance covers BLANK_LZ=0.
module tb_bcd_display_scan;

  logic       Clk = 1'b0;
  logic       Rst = 1'b0;
  logic       Enable = 1'b0;
  logic       Carry = 1'b0;
  logic [3:0] Digit0 = 4'd0;
  logic [3:0] Digit1 = 4'd0;

  logic [7:0] seg, seg_nz;
  logic [1:0] anode, anode_nz;
  logic       valid, valid_nz, ovf, ovf_nz;

  int total = 0;
  int bad = 0;
  int phase = -1;

  bcd_display_scan #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut (
    .Clk(Clk), .Rst(Rst), .Enable(Enable), .Digit0(Digit0), .Digit1(Digit1), .Carry(Carry),
    .Seg(seg), .Anode(anode), .Valid(valid), .Overflow(ovf)
  );

  bcd_display_scan #(.SCAN_DIV(4), .BLANK_LZ(1'b0)) dut_nz (
    .Clk(Clk), .Rst(Rst), .Enable(Enable), .Digit0(Digit0), .Digit1(Digit1), .Carry(Carry),
    .Seg(seg_nz), .Anode(anode_nz), .Valid(valid_nz), .Overflow(ovf_nz)
  );

  always #5 Clk = ~Clk;

  // Position in the 10-cycle scan seen on the outputs: 0-3 units, 4 gap, 5-8 tens, 9 gap.
  always @(posedge Clk) phase <= !Rst ? -1 : (phase + 1) % 10;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic wait_phase(input int p);
    int k = 0;
    @(negedge Clk);
    while (phase != p && k < 25) begin
      @(negedge Clk);
      k++;
    end
    if (phase != p) chk("wait_phase", phase, p);
  endtask

  // Opens a window for len cycles, then drops Enable with the result digits presented.
  task automatic measure(input logic [3:0] d1, input logic [3:0] d0, input int len,
                         input int carry_at, input logic carry_fall);
    Enable = 1'b1;
    for (int i = 0; i < len; i++) begin
      Carry  = (i == carry_at);
      Digit0 = 4'($urandom_range(0, 9));
      Digit1 = 4'($urandom_range(0, 9));
      @(negedge Clk);
    end
    Enable = 1'b0;
    Digit1 = d1;
    Digit0 = d0;
    Carry  = carry_fall;
    @(negedge Clk);
    Carry = 1'b0;
  endtask

  task automatic check_slots(input string tag, input logic [7:0] u, input logic [7:0] t,
                             input logic [7:0] t_nz);
    wait_phase(9);
    wait_phase(3);
    chk({tag, "_u_seg"}, seg, u);
    chk({tag, "_u_an"}, anode, 2'b01);
    chk({tag, "_u_seg_nz"}, seg_nz, u);
    wait_phase(8);
    chk({tag, "_t_seg"}, seg, t);
    chk({tag, "_t_an"}, anode, 2'b10);
    chk({tag, "_t_seg_nz"}, seg_nz, t_nz);
  endtask

  initial begin
    step(3);
    chk("rst_seg", seg, 8'h00);
    chk("rst_anode", anode, 2'b00);
    chk("rst_valid", valid, 1'b0);
    chk("rst_ovf", ovf, 1'b0);

    Rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk("idle_anode", anode, (phase < 4) ? 2'b01 : (phase == 4 || phase == 9) ? 2'b00 : 2'b10);
      chk("idle_seg", seg, (phase == 4 || phase == 9) ? 8'h00 : 8'h40);
    end
    chk("idle_valid", valid, 1'b0);

    measure(4'd4, 4'd7, 6, -1, 1'b0);
    chk("m47_valid", valid, 1'b1);
    chk("m47_ovf", ovf, 1'b0);
    chk("m47_valid_nz", valid_nz, 1'b1);
    check_slots("m47", 8'h07, 8'h66, 8'h66);

    measure(4'd0, 4'd5, 5, -1, 1'b0);
    check_slots("lz", 8'h6D, 8'h00, 8'h3F);
    chk("lz_an_nz", anode_nz, 2'b10);

    measure(4'd1, 4'd2, 7, 3, 1'b0);
    chk("ovf_set", ovf, 1'b1);
    chk("ovf_set_nz", ovf_nz, 1'b1);
    check_slots("ovf", 8'h40, 8'h40, 8'h40);

    measure(4'd2, 4'd3, 4, -1, 1'b0);
    chk("ovf_clr", ovf, 1'b0);
    check_slots("ok23", 8'h4F, 8'h5B, 8'h5B);

    measure(4'd9, 4'd1, 3, -1, 1'b1);
    chk("ovf_fall", ovf, 1'b1);

    measure(4'd8, 4'd6, 5, -1, 1'b0);
    chk("hold_ovf", ovf, 1'b0);
    Digit0 = 4'd1;
    Digit1 = 4'd2;
    check_slots("hold", 8'h7D, 8'h7F, 8'h7F);

    measure(4'd3, 4'd12, 4, -1, 1'b0);
    check_slots("bad_bcd", 8'h40, 8'h4F, 8'h4F);

    Enable = 1'b1;
    Digit0 = 4'd5;
    Digit1 = 4'd5;
    step(2);
    Carry = 1'b1;
    step(1);
    Carry = 1'b0;
    check_slots("en_hi", 8'h40, 8'h4F, 8'h4F);
    chk("en_hi_ovf", ovf, 1'b0);
    chk("en_hi_valid", valid, 1'b1);

    wait_phase(6);
    Rst = 1'b0;
    Enable = 1'b0;
    step(1);
    chk("mid_rst_seg", seg, 8'h00);
    chk("mid_rst_anode", anode, 2'b00);
    chk("mid_rst_valid", valid, 1'b0);
    chk("mid_rst_ovf", ovf, 1'b0);
    Rst = 1'b1;
    step(1);
    chk("restart_anode", anode, 2'b01);
    chk("restart_seg", seg, 8'h40);
    chk("restart_valid", valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_display_scan.md
Name: bcd_display_scan

Overview:
- Output stage of the ramp/comparator BCD measurement chain.
- Sits directly downstream of the two cascaded BCD counters.
- Latches the units/tens digits when the counting window (Enable) closes, holds them stable while the next measurement counts, and drives a two-digit multiplexed 7-segment display with guard blanking, leading-zero blanking and overflow indication.

Parameters:
SCAN_DIV, 16, clock cycles each digit is lit per scan slot (legal range 2..255).
BLANK_LZ, 1, 1 = blank the tens digit when it is 0; 0 = always show it.

Ports:
Clk  input  1  system clock (counter clock domain); all logic on rising edge.
Rst  input  1  synchronous, active-low reset.
Enable  input  1  counting window from the comparator gate; high while the BCD counters count.
Digit0  input  4  units BCD from the first counter.
Digit1  input  4  tens BCD from the second counter.
Carry  input  1  tens-counter rollover pulse (9→0); any high cycle inside the window means overflow.
Seg  output  8  segments, active high: [6:0] = g..a, [7] = dp.
Anode  output  2  digit select, one-hot active high: 01 = units, 10 = tens, 00 = none.
Valid  output  1  high once at least one measurement has been latched.
Overflow  output  1  latched overflow status of the displayed measurement.

Behaviour:
- Reset: Rst=0 at a rising edge gives Seg=0, Anode=00, Valid=0, Overflow=0. Hold registers=0, Enable_d=0, sticky ovf=0, FSM=D0, scan counter=0. Applies mid-scan or mid-window; the next edge with Rst=1 starts fresh.
- Edge detect:
  - Enable_d registers Enable.
  - Capture when Enable_d=1 and Enable=0.
  - Rising window (Enable_d=0, Enable=1) clears the sticky ovf only; displayed data is untouched.
- Sticky ovf: set on any cycle with Enable=1 and Carry=1. A Carry in the same cycle as the capture cycle also counts toward that capture.
- Capture edge:
  - Hold0 ← Digit0, Hold1 ← Digit1.
  - Overflow ← sticky ovf OR Carry.
  - Valid ← 1.
  - Values become visible at the digit's next lit slot. No change to the scan sequence.
- Enable held high forever: no capture; display keeps its old value.
- Scan FSM (free-running, independent of Enable): D0 → G0 → D1 → G1 → D0.
  - D0: Anode=01 for SCAN_DIV cycles.
  - G0: Anode=00, Seg=0 for 1 cycle.
  - D1: Anode=10 for SCAN_DIV cycles.
  - G1: Anode=00, Seg=0 for 1 cycle.
  - Period is 2·SCAN_DIV+2 cycles. The counter wraps to 0 on every state change.
- Output timing: Seg and Anode are registered. The first edge with Rst=1 after reset yields Anode=01 with D0 content.
- Segment code: 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07, 8:7F, 9:6F. Codes 10–15 give 40 (dash). dp is always 0.
- Content priority per digit slot:
  - Valid=0 → 40 on both digits.
  - Overflow=1 → 40 on both digits.
  - D1 with BLANK_LZ=1 and Hold1=0 → Seg=00, Anode=10 (anode still cycles; constant brightness timing).
  - Otherwise the decoded Hold value.
- Inputs Digit0/Digit1 are sampled only on the capture edge. Changes at other times have no effect.

Test Plan:
- Reset/idle, SCAN_DIV=4, Enable=0: Anode sequence 01×4, 00, 10×4, 00, repeating. Seg=40 in lit slots, 00 in gaps. Valid=0.
- Measure 47: Enable high 6 cycles, Digit1=4, Digit0=7 on the falling cycle, no Carry. Next cycle Valid=1, Overflow=0. Slots: units Seg=07, tens Seg=66.
- Leading zero: capture 0/5 with BLANK_LZ=1 → units 6D, tens slot Seg=00 with Anode=10. With BLANK_LZ=0 the tens slot gives 3F.
- Overflow: single Carry pulse mid-window, capture 1/2 → Overflow=1, both slots 40. Next window without Carry, capture 2/3 → Overflow=0, Seg 4F/5B.
- Edge cases:
  - Carry on the same cycle Enable falls → Overflow=1.
  - Digit changes while Enable=0 after capture → display unchanged.
  - Invalid BCD Digit0=12 → 40.
- Reset mid-operation: Rst=0 for one edge during D1 after a valid capture → next edge all outputs 0 and Valid=0. Then the sequence restarts at D0 with Seg=40.
